iob_tdp_ram_loader: RTL
=======================

# iob_tdp_ram_loader

Sequential memory loader that fills a dual-port memory from a valid/ready data stream, one word per accepted beat, over the full 2^ADDR_W address range. It is the write-side counterpart to the iob_tdp_rom/iob_tdp_ram read path: it drives one memory port to populate contents at boot, then optionally reads the contents back and checks them against a running checksum. It sits between a boot data source (UART/SPI byte stream) and one port of an iob_tdp_ram.

## Interface
- DATA_W, 8, memory word and stream data width
- ADDR_W, 4, memory address width; N = 2^ADDR_W words are loaded
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- start  input  1  begin a load; sampled only in IDLE or DONE
- s_valid  input  1  stream word valid
- s_data  input  DATA_W  stream word
- s_ready  output  1  loader accepts a word this cycle
- mem_en  output  1  memory port enable
- mem_we  output  1  memory port write enable
- mem_addr  output  ADDR_W  memory port address
- mem_wdata  output  DATA_W  memory port write data
- mem_rdata  input  DATA_W  memory port read data, valid one cycle after a read
- busy  output  1  high in LOAD, VERIFY, CHECK
- done  output  1  load (and check) complete; held until next start or rst
- error  output  1  readback checksum mismatch; valid when done=1
- checksum  output  DATA_W+ADDR_W  sum of all accepted words, unsigned, no overflow

## Operation
- States: IDLE, LOAD, VERIFY, CHECK, DONE.
- Reset (rst=1): state IDLE; address counter, both sums, busy, done, error, checksum = 0; s_ready, mem_en, mem_we = 0.
- IDLE/DONE: start=1 -> LOAD; address counter, sums, done and error cleared.
- LOAD: s_ready=1. Beat = s_valid && s_ready. On a beat, same cycle: mem_en=1, mem_we=1, mem_addr=counter, mem_wdata=s_data; counter increments; write sum += s_data (zero-extended to DATA_W+ADDR_W). s_valid=0 stalls with no write and no address skip.
- Beat at counter = N-1: counter wraps to 0; next state VERIFY, or DONE when verification is compiled out. s_ready falls the next cycle.
- VERIFY: each cycle mem_en=1, mem_we=0, mem_addr=counter; counter increments. A read-valid flag, delayed one cycle, adds mem_rdata into read sum. After the read at N-1 -> CHECK.
- CHECK: adds the final mem_rdata; error <= (read sum + mem_rdata != write sum); -> DONE.
- DONE: done=1, busy=0, checksum = write sum.
- start while busy is ignored. s_valid outside LOAD is ignored (s_ready=0).
- mem_* outputs are 0 whenever not actively writing or reading.

## Timing
- start sampled at edge k -> s_ready=1 from cycle k+1.
- Write issued combinationally in the beat cycle; memory captures it at that edge.
- Final beat at cycle t: VERIFY reads at t+1..t+N; CHECK at t+N+1; done=1 from t+N+2.
- Verification compiled out: done=1 from t+1.
- Assumed memory read latency exactly 1 cycle (matches iob_tdp_rom/ram).
- rst mid-operation: next cycle all outputs at reset values; partial contents are left in memory, and the next start rewrites from address 0.

## Configuration
- LOADER_VERIFY_EN defined: VERIFY and CHECK states, read sum and read-valid flag are present, and error reflects the readback comparison.
- Not defined: LOAD -> DONE directly; the block never issues reads (mem_we=1 whenever mem_en=1); error is tied to 0; mem_rdata is unused.

## Test plan
- Defaults, LOADER_VERIFY_EN, 1-cycle RAM model: start, stream 0x00..0x0F back-to-back -> mem[i]=i, done 18 cycles after the last beat, checksum=0x078, error=0.
- s_valid toggling every other cycle with data 0xF0..0xFF -> 16 writes, addresses 0..15 with no skip, checksum=0xF78, error=0.
- RAM model corrupts readback at addr 5 (XOR 0x01) -> done=1, error=1, checksum unchanged from the written sum.
- rst asserted after 7 beats -> next cycle busy=s_ready=done=0 and checksum=0; a new start writes beat 0 to addr 0.
- start pulsed during LOAD -> no effect; start in DONE -> done and error clear next cycle and a new load begins at addr 0.
- LOADER_VERIFY_EN undefined, stream 0x00..0x0F -> done at t+1, no mem_en cycle with mem_we=0, error=0.

Source files
------------

// File: rtl/iob_tdp_ram_loader.sv
// -----------------------------------------------------------------------------
// iob_tdp_ram_loader
//
// Purpose:
//    Fills one port of a dual-port memory from a valid/ready word stream, one
//    word per accepted beat, covering all 2^ADDR_W addresses starting at 0.
//    A running checksum of every accepted word is kept. When the optional
//    readback feature is compiled in, the whole memory is read back after the
//    load and the sum of the readback data is compared against the write sum.
//
// Optional feature macro:
//    LOADER_VERIFY_EN - when defined, adds the VERIFY/CHECK readback pass and
//                       drives error from the comparison. When undefined, the
//                       loader goes straight from LOAD to DONE, never reads,
//                       and error is tied low.
//
// Ports:
//    clk        in   system clock, rising edge
//    rst        in   synchronous active-high reset
//    start      in   begin a load (honoured only in IDLE or DONE)
//    s_valid    in   stream word valid
//    s_data     in   stream word [DATA_W]
//    s_ready    out  loader accepts a word this cycle (high throughout LOAD)
//    mem_en     out  memory port enable
//    mem_we     out  memory port write enable
//    mem_addr   out  memory port address [ADDR_W]
//    mem_wdata  out  memory port write data [DATA_W]
//    mem_rdata  in   memory port read data, one cycle after the read
//    busy       out  high in LOAD, VERIFY and CHECK
//    done       out  load (and check) finished; held until start or rst
//    error      out  readback sum mismatch; meaningful while done=1
//    checksum   out  unsigned sum of all accepted words [DATA_W+ADDR_W]
// -----------------------------------------------------------------------------
module iob_tdp_ram_loader #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     s_valid,
   input  logic [DATA_W-1:0]        s_data,
   output logic                     s_ready,
   output logic                     mem_en,
   output logic                     mem_we,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [DATA_W-1:0]        mem_wdata,
   input  logic [DATA_W-1:0]        mem_rdata,
   output logic                     busy,
   output logic                     done,
   output logic                     error,
   output logic [DATA_W+ADDR_W-1:0] checksum
);

   localparam int SUM_W = DATA_W + ADDR_W;

   // Last address of the range; the beat or read here ends the pass.
   localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_VERIFY = 3'd2,
      ST_CHECK  = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   // Registered state and outputs
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [SUM_W-1:0]  wsum_q, wsum_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              error_q, error_d;
   logic [SUM_W-1:0]  checksum_q, checksum_d;

`ifdef LOADER_VERIFY_EN
   // Readback accumulator and the one-cycle-delayed "read data is valid" flag
   logic [SUM_W-1:0]  rsum_q, rsum_d;
   logic              rvalid_q, rvalid_d;
   logic [SUM_W-1:0]  rdata_ext_s;
   logic [SUM_W-1:0]  rsum_final_s;
`else
   // mem_rdata has no consumer when the readback pass is compiled out
   logic              unused_rdata_s;
   assign unused_rdata_s = ^mem_rdata;
`endif

   logic              beat_s;
   logic [SUM_W-1:0]  sdata_ext_s;
   logic [SUM_W-1:0]  wsum_next_s;

   assign busy     = busy_q;
   assign done     = done_q;
   assign error    = error_q;
   assign checksum = checksum_q;

   // Stream handshake and memory port: decoded from the current state so a
   // write lands in the same cycle as its beat.
   always_comb begin
      s_ready     = (state_q == ST_LOAD);
      beat_s      = s_valid && s_ready;
      sdata_ext_s = {{ADDR_W{1'b0}}, s_data};
      wsum_next_s = wsum_q + sdata_ext_s;
`ifdef LOADER_VERIFY_EN
      rdata_ext_s  = {{ADDR_W{1'b0}}, mem_rdata};
      rsum_final_s = rsum_q + rdata_ext_s;
`endif
      mem_en      = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = {ADDR_W{1'b0}};
      mem_wdata   = {DATA_W{1'b0}};
      case (state_q)
         ST_LOAD: begin
            if (beat_s) begin
               mem_en    = 1'b1;
               mem_we    = 1'b1;
               mem_addr  = addr_q;
               mem_wdata = s_data;
            end else begin
               mem_en    = 1'b0;
            end
         end
`ifdef LOADER_VERIFY_EN
         ST_VERIFY: begin
            mem_en   = 1'b1;
            mem_addr = addr_q;
         end
`endif
         default: begin
            mem_en = 1'b0;
         end
      endcase
   end

   // Next-state and next-register values for the loader FSM
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wsum_d     = wsum_q;
      busy_d     = busy_q;
      done_d     = done_q;
      error_d    = error_q;
      checksum_d = checksum_q;
`ifdef LOADER_VERIFY_EN
      rsum_d     = rsum_q;
      rvalid_d   = (state_q == ST_VERIFY);
`endif
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d    = ST_LOAD;
               addr_d     = {ADDR_W{1'b0}};
               wsum_d     = {SUM_W{1'b0}};
               busy_d     = 1'b1;
               done_d     = 1'b0;
               error_d    = 1'b0;
               checksum_d = {SUM_W{1'b0}};
`ifdef LOADER_VERIFY_EN
               rsum_d     = {SUM_W{1'b0}};
`endif
            end else begin
               state_d = state_q;
            end
         end
         ST_LOAD: begin
            if (beat_s) begin
               // Counter wraps back to 0 after the last address, which is
               // exactly where the readback pass starts.
               addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
               wsum_d = wsum_next_s;
               if (addr_q == LAST_ADDR) begin
`ifdef LOADER_VERIFY_EN
                  state_d    = ST_VERIFY;
`else
                  state_d    = ST_DONE;
                  busy_d     = 1'b0;
                  done_d     = 1'b1;
                  checksum_d = wsum_next_s;
`endif
               end else begin
                  state_d = ST_LOAD;
               end
            end else begin
               state_d = ST_LOAD;
            end
         end
`ifdef LOADER_VERIFY_EN
         ST_VERIFY: begin
            addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            // The first VERIFY cycle has no read data in flight yet.
            if (rvalid_q) begin
               rsum_d = rsum_final_s;
            end else begin
               rsum_d = rsum_q;
            end
            if (addr_q == LAST_ADDR) begin
               state_d = ST_CHECK;
            end else begin
               state_d = ST_VERIFY;
            end
         end
         ST_CHECK: begin
            // The read of the last address returns here and is folded in
            // directly rather than through rsum_q.
            rsum_d     = rsum_final_s;
            error_d    = (rsum_final_s != wsum_q);
            state_d    = ST_DONE;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            checksum_d = wsum_q;
         end
`endif
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
         end
      endcase
   end

   // Loader state register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         addr_q     <= {ADDR_W{1'b0}};
         wsum_q     <= {SUM_W{1'b0}};
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         checksum_q <= {SUM_W{1'b0}};
`ifdef LOADER_VERIFY_EN
         rsum_q     <= {SUM_W{1'b0}};
         rvalid_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wsum_q     <= wsum_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
         checksum_q <= checksum_d;
`ifdef LOADER_VERIFY_EN
         rsum_q     <= rsum_d;
         rvalid_q   <= rvalid_d;
`endif
      end
   end

endmodule
